// File: rtl/servo_slew_sequencer.sv
// servo_slew_sequencer
//   Feeds the four-channel servo PWM controller. The host writes per-channel
//   target widths at any time. Once per frame, each channel's commanded width
//   moves toward its target by at most STEP counts. The new widths are then
//   loaded into the PWM controller over its cs/addr/data port, which limits
//   servo slew rate and keeps compare updates at frame boundaries.
//
//   Build option: define SERVO_TARGET_CLAMP_EN to clamp host writes to
//   [MIN_PULSE, MAX_PULSE] before they are stored as targets.
//
// Ports
//   clk      system clock
//   rst      synchronous, active-high reset
//   wr_en    host target write strobe
//   wr_addr  channel addressed by the host write
//   wr_data  target pulse width
//   cs       load strobe to the PWM controller (registered)
//   addr     channel being loaded (registered)
//   data     width being loaded (registered)
//   frame    one-cycle pulse on the last cycle of each frame
//   settled  bit i high when channel i has reached its target
module servo_slew_sequencer #(
    parameter int unsigned SIGNAL_BIT_WIDTH  = 15,
    parameter int unsigned ADDRESS_BIT_WIDTH = 2,
    parameter int unsigned PWM_SIGNAL_COUNT  = 4,
    parameter int unsigned FULL_CYCLE        = 20000,
    parameter int unsigned STEP              = 10,
    parameter int unsigned RESET_PULSE       = 1500,
    parameter int unsigned MIN_PULSE         = 500,
    parameter int unsigned MAX_PULSE         = 2500
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDRESS_BIT_WIDTH-1:0] wr_addr,
    input  logic [SIGNAL_BIT_WIDTH-1:0]  wr_data,
    output logic                         cs,
    output logic [ADDRESS_BIT_WIDTH-1:0] addr,
    output logic [SIGNAL_BIT_WIDTH-1:0]  data,
    output logic                         frame,
    output logic [PWM_SIGNAL_COUNT-1:0]  settled
);

    localparam int unsigned W     = SIGNAL_BIT_WIDTH;
    localparam int unsigned A     = ADDRESS_BIT_WIDTH;
    localparam int unsigned N     = PWM_SIGNAL_COUNT;
    localparam int unsigned CNT_W = $clog2(FULL_CYCLE);

    localparam logic [W-1:0]     RESET_W  = W'(RESET_PULSE);
    localparam logic [A-1:0]     LAST_CH  = A'(N - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FULL_CYCLE - 1);
    localparam logic [W:0]       STEP_X   = (W + 1)'(STEP);

    // Parameter sanity checks, evaluated at elaboration only.
    if (N != 2 ** A) begin : g_bad_count
        $error("PWM_SIGNAL_COUNT must equal 2**ADDRESS_BIT_WIDTH");
    end
    if (N < 2 || FULL_CYCLE <= N + 1) begin : g_bad_frame
        $error("FULL_CYCLE must leave room for a full update pass");
    end
    if (MIN_PULSE > MAX_PULSE) begin : g_bad_clamp
        $error("MIN_PULSE must not exceed MAX_PULSE");
    end

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        UPDATE
    } state_t;

    state_t           state, state_nxt;
    logic [A-1:0]     ch, ch_nxt;
    logic [CNT_W-1:0] frame_cnt;
    logic [W-1:0]     target  [N];
    logic [W-1:0]     current [N];

    logic             load_en;
    logic             upd_en;
    logic [A-1:0]     load_ch;
    logic [W-1:0]     load_data;
    logic [W-1:0]     new_val;
    logic [W-1:0]     wr_val;

    // Move cur toward tgt by at most STEP. The distance is computed one bit
    // wider than the data, so the result can never overshoot or wrap.
    function automatic logic [W-1:0] slew(input logic [W-1:0] cur,
                                          input logic [W-1:0] tgt);
        logic [W:0] c;
        logic [W:0] t;
        logic [W:0] r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        r = c;
        if (c < t) begin
            r = ((t - c) <= STEP_X) ? t : c + STEP_X;
        end else if (c > t) begin
            r = ((c - t) <= STEP_X) ? t : c - STEP_X;
        end
        return r[W-1:0];
    endfunction

`ifdef SERVO_TARGET_CLAMP_EN
    localparam logic [W-1:0] MIN_W = W'(MIN_PULSE);
    localparam logic [W-1:0] MAX_W = W'(MAX_PULSE);

    always_comb begin
        wr_val = wr_data;
        if (wr_data < MIN_W) begin
            wr_val = MIN_W;
        end else if (wr_data > MAX_W) begin
            wr_val = MAX_W;
        end
    end
`else
    assign wr_val = wr_data;
`endif

    assign frame = (frame_cnt == LAST_CNT);

    for (genvar gi = 0; gi < N; gi++) begin : g_settled
        assign settled[gi] = (current[gi] == target[gi]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
        end
    end

    // Next-state logic.
    // Channel 0 is stepped on the frame cycle itself, so that its registered
    // load appears one cycle after the pulse. UPDATE then covers channels
    // 1..N-1.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        unique case (state)
            INIT: begin
                ch_nxt = ch + 1'b1;
                if (ch == LAST_CH) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (frame) begin
                    ch_nxt    = A'(1);
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                ch_nxt = ch + 1'b1;
                if (ch == LAST_CH) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                ch_nxt    = '0;
                state_nxt = INIT;
            end
        endcase
    end

    // Output / load-selection logic
    always_comb begin
        load_en = 1'b0;
        upd_en  = 1'b0;
        load_ch = ch;
        unique case (state)
            INIT: begin
                load_en = 1'b1;
            end
            IDLE: begin
                if (frame) begin
                    load_en = 1'b1;
                    upd_en  = 1'b1;
                    load_ch = '0;
                end
            end
            UPDATE: begin
                load_en = 1'b1;
                upd_en  = 1'b1;
            end
            default: begin
                load_en = 1'b0;
            end
        endcase
        new_val   = slew(current[load_ch], target[load_ch]);
        load_data = upd_en ? new_val : current[load_ch];
    end

    // Datapath registers: frame counter, channel state, load port.
    // The update reads the target register before this edge's host write
    // lands, so a same-cycle write takes effect from the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            cs        <= 1'b0;
            addr      <= '0;
            data      <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                target[i]  <= RESET_W;
                current[i] <= RESET_W;
            end
        end else begin
            frame_cnt <= frame ? '0 : frame_cnt + 1'b1;
            cs        <= load_en;
            addr      <= load_en ? load_ch : '0;
            data      <= load_en ? load_data : '0;
            if (upd_en) begin
                current[load_ch] <= new_val;
            end
            if (wr_en) begin
                target[wr_addr] <= wr_val;
            end
        end
    end

endmodule

// File: tb/tb_servo_slew_sequencer.sv
module tb_servo_slew_sequencer;

    localparam int W    = 15;
    localparam int A    = 2;
    localparam int N    = 4;
    localparam int FC   = 100;
    localparam int STEP = 10;
    localparam int RP   = 1500;
    localparam int MINP = 500;
    localparam int MAXP = 2500;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         cs;
    logic [A-1:0] addr;
    logic [W-1:0] data;
    logic         frame;
    logic [N-1:0] settled;

    always #5 clk = ~clk;

    servo_slew_sequencer #(
        .SIGNAL_BIT_WIDTH (W),
        .ADDRESS_BIT_WIDTH(A),
        .PWM_SIGNAL_COUNT (N),
        .FULL_CYCLE       (FC),
        .STEP             (STEP),
        .RESET_PULSE      (RP),
        .MIN_PULSE        (MINP),
        .MAX_PULSE        (MAXP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .cs     (cs),
        .addr   (addr),
        .data   (data),
        .frame  (frame),
        .settled(settled)
    );

    // Scoreboard entry: the load expected on post-reset cycle n.
    typedef struct {
        int n;
        int a;
        int d;
    } load_t;

    load_t q[$];
    int    m_tgt[N];
    int    m_cur[N];
    int    m_n      = 0;
    bit    checking = 1'b0;
    int    total    = 0;
    int    bad      = 0;

    function automatic int clampv(input int v);
`ifdef SERVO_TARGET_CLAMP_EN
        if (v < MINP) return MINP;
        if (v > MAXP) return MAXP;
`endif
        return v;
    endfunction

    // Reference model. m_n counts clock edges since the reset edge. INIT loads
    // land on cycles 1..N. A frame pulse is on every cycle n with
    // n mod FC == FC-1. Channel c is stepped and loaded on cycle k*FC+c.
    // A host write applies after that cycle's step.
    always @(posedge clk) begin : model
        int c;
        if (rst) begin
            m_n = 0;
            q.delete();
            for (int i = 0; i < N; i++) begin
                m_tgt[i] = RP;
                m_cur[i] = RP;
            end
        end else begin
            m_n++;
            if (m_n <= N) q.push_back('{m_n, m_n - 1, m_cur[m_n - 1]});
            c = m_n % FC;
            if (m_n >= FC && c < N) begin
                if (m_cur[c] < m_tgt[c])
                    m_cur[c] = (m_cur[c] + STEP > m_tgt[c]) ? m_tgt[c] : m_cur[c] + STEP;
                else if (m_cur[c] > m_tgt[c])
                    m_cur[c] = (m_cur[c] - STEP < m_tgt[c]) ? m_tgt[c] : m_cur[c] - STEP;
                q.push_back('{m_n, c, m_cur[c]});
            end
            if (wr_en) m_tgt[wr_addr] = clampv(int'(wr_data));
        end
    end

    // Monitor: pops and compares whenever a load is presented or expected.
    always @(negedge clk) begin : monitor
        bit           exp_cs;
        bit           exp_frame;
        logic [N-1:0] exp_settled;
        load_t        e;
        if (checking) begin
            exp_cs = (q.size() > 0) && (q[0].n == m_n);
            if (cs || exp_cs) begin
                total++;
                if (!exp_cs) begin
                    bad++;
                    $display("FAIL load_unexpected n=%0d: got cs=1 addr=%0d data=%0d, expected cs=0",
                             m_n, addr, data);
                end else begin
                    e = q.pop_front();
                    if (cs !== 1'b1 || int'(addr) != e.a || int'(data) != e.d) begin
                        bad++;
                        $display("FAIL load n=%0d: got cs=%0b addr=%0d data=%0d, expected cs=1 addr=%0d data=%0d",
                                 m_n, cs, addr, data, e.a, e.d);
                    end
                end
            end
            exp_frame = ((m_n % FC) == FC - 1);
            if (frame || exp_frame) begin
                total++;
                if (frame !== exp_frame) begin
                    bad++;
                    $display("FAIL frame n=%0d: got %0b, expected %0b", m_n, frame, exp_frame);
                end
            end
            for (int i = 0; i < N; i++) exp_settled[i] = (m_cur[i] == m_tgt[i]);
            total++;
            if (settled !== exp_settled) begin
                bad++;
                $display("FAIL settled n=%0d: got %b, expected %b", m_n, settled, exp_settled);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance so that the next drive is sampled on the edge of cycle x.
    task automatic goto(input int x);
        while (m_n < x - 1) step();
    endtask

    task automatic host_write(input int ch, input int val);
        wr_en   = 1'b1;
        wr_addr = A'(ch);
        wr_data = W'(val);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic check_const(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int r;
        int v;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        step();
        step();
        check_const("reset_cs", int'(cs), 0);
        check_const("reset_addr", int'(addr), 0);
        check_const("reset_data", int'(data), 0);
        check_const("reset_frame", int'(frame), 0);
        check_const("reset_settled", int'(settled), 15);
        checking = 1'b1;
        rst      = 1'b0;
        repeat (6) step();

        // Ramp up, partial step, large target.
        host_write(0, 1530);
        host_write(1, 1495);
        host_write(2, 3000);

        // Write ch3 on the very cycle it is stepped in the first frame.
        goto(FC + 3);
        host_write(3, 1600);

        // Reset right after the addr1 load of the fifth frame.
        goto(5 * FC + 2);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 150 * FC; k++) begin
            r = $urandom_range(0, 2999);
            if (r < 100) begin
                case ($urandom_range(0, 3))
                    0: v = RP - 40 + $urandom_range(0, 80);
                    1: v = $urandom_range(0, 32767);
                    2: v = 1400 + $urandom_range(0, 200);
                    default: v = RP;
                endcase
                host_write($urandom_range(0, N - 1), v);
            end else if (r == 100) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        repeat (3 * FC) step();
        @(negedge clk);
        #1;
        check_const("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
